// File: rtl/if_stage_if.sv
// Instruction-memory fetch bus between if_stage (master) and the imem (slave).
// Memory accepts and returns data in the same cycle as ready.
interface if_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (output imem_req, imem_addr, input  imem_ready, imem_rdata);
  modport slave  (input  imem_req, imem_addr, output imem_ready, imem_rdata);
endinterface

// File: rtl/if_stage.sv
// Instruction fetch stage: PC, imem handshake, IF/ID register, stall/redirect FSM.
// Optional macro IF_STAGE_PERF_CNT_EN adds a saturating stall-cycle counter.
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_PC_write,
  input  logic              i_IF_ID_write,
  input  logic              i_branch_taken,
  input  logic [31:0]       i_branch_target,
  if_stage_if.master        imem,
  output logic [31:0]       o_IF_ID_pc,
  output logic [31:0]       o_IF_ID_pc4,
  output logic [31:0]       o_IF_ID_instr,
  output logic              o_IF_ID_valid
`ifdef IF_STAGE_PERF_CNT_EN
  ,
  output logic [31:0]       o_stall_cycles
`endif
);

  typedef enum logic [1:0] {FETCH, HOLD, DISCARD} state_t;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] instr;
    logic        valid;
  } ifid_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d, tgt_q, tgt_d, hold_q, hold_d;
  ifid_t       ifid_q, ifid_d, bubble;
  logic        req_en_q, req, comp, go;
  logic [31:0] pc_inc, tgt_al;

  // req_en delays the first request by one cycle after reset release
  assign req    = req_en_q && (state_q != HOLD);
  assign comp   = req && imem.imem_ready;
  assign go     = i_PC_write && i_IF_ID_write;
  assign pc_inc = pc_q + 32'd4;
  assign tgt_al = i_branch_target & ~32'h3;
  assign bubble = '{pc: ifid_q.pc, pc4: ifid_q.pc4, instr: NOP_INSTR, valid: 1'b0};

  assign imem.imem_req  = req;
  assign imem.imem_addr = pc_q;
  assign o_IF_ID_pc     = ifid_q.pc;
  assign o_IF_ID_pc4    = ifid_q.pc4;
  assign o_IF_ID_instr  = ifid_q.instr;
  assign o_IF_ID_valid  = ifid_q.valid;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    tgt_d   = tgt_q;
    hold_d  = hold_q;
    ifid_d  = ifid_q;
    unique case (state_q)
      FETCH: begin
        if (i_branch_taken) begin
          ifid_d = bubble;
          hold_d = '0;
          if (comp || !req) pc_d = tgt_al;
          else begin
            tgt_d   = tgt_al;
            state_d = DISCARD;
          end
        end else if (comp) begin
          if (go) begin
            ifid_d = '{pc: pc_q, pc4: pc_inc, instr: imem.imem_rdata, valid: 1'b1};
            pc_d   = pc_inc;
          end else begin
            // pc stays put in HOLD, so it doubles as the held word's PC
            hold_d  = imem.imem_rdata;
            state_d = HOLD;
          end
        end else if (i_IF_ID_write) begin
          ifid_d = bubble;
        end
      end
      HOLD: begin
        if (i_branch_taken) begin
          ifid_d  = bubble;
          hold_d  = '0;
          pc_d    = tgt_al;
          state_d = FETCH;
        end else if (go) begin
          ifid_d  = '{pc: pc_q, pc4: pc_inc, instr: hold_q, valid: 1'b1};
          pc_d    = pc_inc;
          state_d = FETCH;
        end
      end
      DISCARD: begin
        ifid_d = bubble;
        if (i_branch_taken) tgt_d = tgt_al;
        if (comp) begin
          pc_d    = i_branch_taken ? tgt_al : tgt_q;
          state_d = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= FETCH;
      pc_q     <= RESET_PC;
      tgt_q    <= '0;
      hold_q   <= '0;
      req_en_q <= 1'b0;
      ifid_q   <= '{pc: 32'd0, pc4: 32'd0, instr: NOP_INSTR, valid: 1'b0};
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      tgt_q    <= tgt_d;
      hold_q   <= hold_d;
      req_en_q <= 1'b1;
      ifid_q   <= ifid_d;
    end
  end

`ifdef IF_STAGE_PERF_CNT_EN
  logic [31:0] stall_q;
  assign o_stall_cycles = stall_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      stall_q <= '0;
    else if ((!i_IF_ID_write || !comp) && stall_q != 32'hFFFF_FFFF)
      stall_q <= stall_q + 32'd1;
  end
`endif

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: imem returns the fetch address as data.
module tb_if_stage;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        pc_write, ifid_write, br_taken;
  logic [31:0] br_target;
  logic [31:0] id_pc, id_pc4, id_instr;
  logic        id_valid;
  int          checks = 0;
  int          errors = 0;

  if_stage_if bus ();
  assign bus.imem_rdata = bus.imem_addr;

`ifdef IF_STAGE_PERF_CNT_EN
  logic [31:0] stall_cycles;
`endif

  if_stage dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_PC_write      (pc_write),
    .i_IF_ID_write   (ifid_write),
    .i_branch_taken  (br_taken),
    .i_branch_target (br_target),
    .imem            (bus),
    .o_IF_ID_pc      (id_pc),
    .o_IF_ID_pc4     (id_pc4),
    .o_IF_ID_instr   (id_instr),
    .o_IF_ID_valid   (id_valid)
`ifdef IF_STAGE_PERF_CNT_EN
    ,
    .o_stall_cycles  (stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ifid(input string tag, input logic [31:0] pc, input logic [31:0] instr);
    chk({tag, ".valid"}, {31'd0, id_valid}, 32'd1);
    chk({tag, ".pc"}, id_pc, pc);
    chk({tag, ".pc4"}, id_pc4, pc + 32'd4);
    chk({tag, ".instr"}, id_instr, instr);
  endtask

  task automatic bub(input string tag);
    chk({tag, ".valid"}, {31'd0, id_valid}, 32'd0);
    chk({tag, ".instr"}, id_instr, 32'h0000_0013);
  endtask

  initial begin
    rst_n = 1'b0; pc_write = 1'b1; ifid_write = 1'b1;
    br_taken = 1'b0; br_target = '0; bus.imem_ready = 1'b1;
    #12;
    chk("rst.req",   {31'd0, bus.imem_req}, 32'd0);
    chk("rst.addr",  bus.imem_addr, 32'd0);
    chk("rst.pc",    id_pc, 32'd0);
    chk("rst.pc4",   id_pc4, 32'd0);
    bub("rst");

    // release between edges; first edge only raises the request
    @(negedge clk); rst_n = 1'b1;
    tick();
    chk("e1.req",  {31'd0, bus.imem_req}, 32'd1);
    chk("e1.addr", bus.imem_addr, 32'd0);
    bub("e1");
    tick(); ifid("e2", 32'd0, 32'd0);
    chk("e2.addr", bus.imem_addr, 32'd4);
    tick(); ifid("e3", 32'd4, 32'd4);

    // memory wait states: three bubbles, address held
    bus.imem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      bub("wait");
      chk("wait.addr", bus.imem_addr, 32'd8);
      chk("wait.req",  {31'd0, bus.imem_req}, 32'd1);
    end
    bus.imem_ready = 1'b1;
    tick(); ifid("wdone", 32'd8, 32'd8);

    // stall on completion -> HOLD, IF/ID frozen
    pc_write = 1'b0; ifid_write = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("hold.req", {31'd0, bus.imem_req}, 32'd0);
      ifid("hold.frozen", 32'd8, 32'd8);
    end
    pc_write = 1'b1; ifid_write = 1'b1;
    tick(); ifid("hold.rel", 32'hC, 32'hC);
    chk("hold.addr", bus.imem_addr, 32'h10);

    // jump to 0x40, then redirect to 0x103 while 0x40 is pending
    br_taken = 1'b1; br_target = 32'h40;
    tick(); bub("br40");
    chk("br40.addr", bus.imem_addr, 32'h40);
    bus.imem_ready = 1'b0; br_target = 32'h103;
    tick(); bub("disc1");
    chk("disc1.addr", bus.imem_addr, 32'h40);
    br_taken = 1'b0;
    tick(); bub("disc2");
    chk("disc2.addr", bus.imem_addr, 32'h40);
    bus.imem_ready = 1'b1;
    tick(); bub("disc3");
    chk("disc3.addr", bus.imem_addr, 32'h100);
    tick(); ifid("tgt", 32'h100, 32'h100);

    // PC wrap
    br_taken = 1'b1; br_target = 32'hFFFF_FFFC;
    tick(); bub("brwrap");
    br_taken = 1'b0;
    tick();
    chk("wrap.valid", {31'd0, id_valid}, 32'd1);
    chk("wrap.pc",    id_pc, 32'hFFFF_FFFC);
    chk("wrap.pc4",   id_pc4, 32'd0);
    chk("wrap.addr",  bus.imem_addr, 32'd0);

    // redirect during a stall still inserts a bubble and takes the target
    pc_write = 1'b0; ifid_write = 1'b0; br_taken = 1'b1; br_target = 32'h200;
    tick(); bub("brstall");
    chk("brstall.addr", bus.imem_addr, 32'h200);
    pc_write = 1'b1; ifid_write = 1'b1; br_taken = 1'b0;
    tick(); ifid("brstall.next", 32'h200, 32'h200);

    // async reset mid-fetch
    bus.imem_ready = 1'b0;
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("arst.req",  {31'd0, bus.imem_req}, 32'd0);
    chk("arst.addr", bus.imem_addr, 32'd0);
    chk("arst.pc",   id_pc, 32'd0);
    bub("arst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
